// File: rtl/cic_decim_param_if.sv
// Sample-stream bundle between the front end, the CIC decimator and its consumer.
// The master drives input samples; the slave (decimator) drives the decimated stream.
interface cic_decim_param_if #(
  parameter int NIN  = 12,
  parameter int NOUT = 16
);
  logic                   din_valid;
  logic signed [NIN-1:0]  din;
  logic                   dout_valid;
  logic signed [NOUT-1:0] dout;
  logic                   dout_sat;

  modport master (output din_valid, din, input dout_valid, dout, dout_sat);
  modport slave  (input din_valid, din, output dout_valid, dout, dout_sat);
endinterface

// File: rtl/cic_decim_param.sv
// Runtime-configurable NSTAGE-stage CIC decimator (M=1) with a pipelined integrator
// chain, registered comb chain and a saturating arithmetic-shift output stage.
module cic_decim_param #(
  parameter  int NIN    = 12,
  parameter  int NSTAGE = 3,
  parameter  int RMAX   = 16,
  parameter  int NOUT   = 16,
  localparam int RW     = $clog2(RMAX) + 1,
  localparam int NMAX   = NIN + NSTAGE * $clog2(RMAX),
  localparam int SW     = $clog2(NMAX)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            restart,
  input  logic [RW-1:0]   dec_ratio,
  input  logic [SW-1:0]   gain_shift,
  cic_decim_param_if.slave bus
);

  typedef logic signed [NMAX-1:0] acc_t;

  localparam acc_t YMAX = acc_t'(2 ** (NOUT - 1) - 1);
  localparam acc_t YMIN = ~YMAX;

  logic          clear;
  logic [RW-1:0] r_q;
  logic [RW-1:0] cnt;
  logic [SW-1:0] s_q;

  acc_t integ  [NSTAGE];
  acc_t comb   [NSTAGE];
  acc_t comb_d [NSTAGE];
  acc_t stage_in [NSTAGE];
  acc_t dec_q;

  logic              dec_stb;
  logic              cap_stb;
  logic [NSTAGE-1:0] comb_stb;
  logic [NSTAGE:0]   stage_go;

  acc_t                   y;
  logic signed [NOUT-1:0] y_out;
  logic                   y_sat;

  assign clear = !rstn || restart;

  // stage_go[k] enables comb stage k; the top bit is the output-register strobe.
  assign stage_go = {comb_stb, cap_stb};

  always_comb begin
    stage_in[0] = dec_q;
    for (int k = 1; k < NSTAGE; k++) stage_in[k] = comb[k-1];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      // NOTE: the integrator/comb arrays are real state that must start from zero for
      // the combs to cancel the integrators, so every element is cleared, not just flags.
      for (int k = 0; k < NSTAGE; k++) begin
        integ[k]  <= '0;
        comb[k]   <= '0;
        comb_d[k] <= '0;
      end
      dec_q    <= '0;
      cnt      <= '0;
      dec_stb  <= 1'b0;
      cap_stb  <= 1'b0;
      comb_stb <= '0;
      r_q      <= (dec_ratio == '0 || int'(dec_ratio) > RMAX) ? RW'(RMAX) : dec_ratio;
      s_q      <= (int'(gain_shift) >= NMAX) ? SW'(NMAX - 1) : gain_shift;
    end else begin
      dec_stb <= 1'b0;
      if (bus.din_valid) begin
        // Each integrator consumes its predecessor's pre-edge value: a pipelined chain
        // that wraps modulo 2^NMAX by design.
        integ[0] <= integ[0] + acc_t'(bus.din);
        for (int k = 1; k < NSTAGE; k++) integ[k] <= integ[k] + integ[k-1];
        if (cnt == r_q - 1'b1) begin
          cnt     <= '0;
          dec_stb <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      cap_stb <= dec_stb;
      if (dec_stb) dec_q <= integ[NSTAGE-1];

      for (int k = 0; k < NSTAGE; k++) begin
        if (stage_go[k]) begin
          comb[k]   <= stage_in[k] - comb_d[k];
          comb_d[k] <= stage_in[k];
        end
      end
      comb_stb <= stage_go[NSTAGE-1:0];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the branches, so no
    // path leaves a value unassigned and no latch is inferred.
    y     = comb[NSTAGE-1] >>> s_q;
    y_out = y[NOUT-1:0];
    y_sat = 1'b0;
    if (y > YMAX) begin
      y_out = YMAX[NOUT-1:0];
      y_sat = 1'b1;
    end else if (y < YMIN) begin
      y_out = YMIN[NOUT-1:0];
      y_sat = 1'b1;
    end
  end

  // dout/dout_sat hold between strobes; dout_valid is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.dout_sat   <= 1'b0;
    end else begin
      bus.dout_valid <= stage_go[NSTAGE];
      if (stage_go[NSTAGE]) begin
        bus.dout     <= y_out;
        bus.dout_sat <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_param.sv
// Self-checking bench for cic_decim_param: a CIC impulse-response model (boxcar^N
// convolution sampled at the decimation points) scores every output cycle.
module tb_cic_decim_param;

  localparam int NIN    = 12;
  localparam int NSTAGE = 3;
  localparam int RMAX   = 16;
  localparam int NOUT   = 16;
  localparam int RW     = $clog2(RMAX) + 1;
  localparam int NMAX   = NIN + NSTAGE * $clog2(RMAX);
  localparam int SW     = $clog2(NMAX);
  localparam int LAT    = NSTAGE + 2;
  localparam int HMAX   = NSTAGE * (RMAX - 1) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          restart = 1'b0;
  logic [RW-1:0] dec_ratio = '0;
  logic [SW-1:0] gain_shift = '0;

  cic_decim_param_if #(.NIN(NIN), .NOUT(NOUT)) bus ();

  cic_decim_param #(.NIN(NIN), .NSTAGE(NSTAGE), .RMAX(RMAX), .NOUT(NOUT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .restart    (restart),
    .dec_ratio  (dec_ratio),
    .gain_shift (gain_shift),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint val;
    bit     sat;
    bit     settled;
  } exp_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   exp_q[$];
  int     hist[$];
  longint h[HMAX];
  int     hlen;
  int     r_m, s_m, acc_n, out_n;
  int     edge_n = 0;
  bit     mon_en = 1'b0;
  int     strobe_cnt = 0;
  int     first_edge = -1;
  longint strobe_sum = 0;
  longint last_dout = 0;
  bit     last_sat = 1'b0;
  int     rs_edge;
  longint hsum;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, edge_n);
    end
  endtask

  // Configuration clamp and the CIC impulse response h = boxcar(R) convolved NSTAGE times.
  function automatic void load_cfg(input int r, input int s);
    longint tmp[HMAX];
    r_m  = (r == 0 || r > RMAX) ? RMAX : r;
    s_m  = (s >= NMAX) ? NMAX - 1 : s;
    h    = '{default: 0};
    h[0] = 1;
    hlen = 1;
    repeat (NSTAGE) begin
      tmp = '{default: 0};
      for (int i = 0; i < hlen; i++)
        for (int j = 0; j < r_m; j++) tmp[i+j] += h[i];
      hlen += r_m - 1;
      h = tmp;
    end
  endfunction

  // Output for accepted sample n: FIR of the sample history (the pipelined integrators
  // add NSTAGE-1 samples of delay), wrapped to NMAX bits, shifted and saturated.
  function automatic void predict(input int n, output longint y, output bit sat);
    longint acc;
    logic signed [NMAX-1:0] w;
    longint lim_hi, lim_lo;
    acc = 0;
    for (int j = 0; j < hlen; j++) begin
      int i;
      i = n - (NSTAGE - 1) - j;
      if (i >= 0) acc += h[j] * longint'(hist[i]);
    end
    w      = acc[NMAX-1:0];
    y      = longint'(w) >>> s_m;
    lim_hi = (longint'(1) <<< (NOUT - 1)) - 1;
    lim_lo = -lim_hi - 1;
    sat    = 1'b0;
    if (y > lim_hi) begin
      y   = lim_hi;
      sat = 1'b1;
    end else if (y < lim_lo) begin
      y   = lim_lo;
      sat = 1'b1;
    end
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model for that edge.
  task automatic tick(input bit rn, input bit rs, input bit v, input int d);
    longint yv;
    bit     ys;
    rstn          = rn;
    restart       = rs;
    bus.din_valid = v;
    bus.din       = NIN'(d);
    @(posedge clk);
    edge_n++;
    if (!rn || rs) begin
      load_cfg(int'(dec_ratio), int'(gain_shift));
      hist.delete();
      exp_q.delete();
      acc_n = 0;
      out_n = 0;
    end else if (v) begin
      hist.push_back(d);
      acc_n++;
      if (acc_n % r_m == 0) begin
        predict(acc_n - 1, yv, ys);
        exp_q.push_back('{edge_n + LAT, yv, ys, out_n >= r_m * NSTAGE});
        out_n++;
      end
    end
    #1;
  endtask

  // Compare process: strobe timing every cycle, value/saturation on settled strobes.
  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (mon_en) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].due <= edge_n);
      check("dout_valid", bus.dout_valid, exp_v);
      if (bus.dout_valid === 1'b1) begin
        strobe_cnt++;
        if (first_edge < 0) first_edge = edge_n;
        strobe_sum += bus.dout;
        last_dout   = bus.dout;
        last_sat    = bus.dout_sat;
      end
      if (exp_v) begin
        e = exp_q.pop_front();
        if (bus.dout_valid === 1'b1 && e.settled) begin
          check("dout", bus.dout, e.val);
          check("dout_sat", bus.dout_sat, e.sat);
        end
      end
    end
  end

  task automatic do_restart(input int r, input int s, input int d);
    dec_ratio  = RW'(r);
    gain_shift = SW'(s);
    tick(1'b1, 1'b1, 1'b1, d);
    rs_edge    = edge_n;
    first_edge = -1;
    strobe_cnt = 0;
  endtask

  initial begin
    bus.din_valid = 1'b0;
    bus.din       = '0;

    // Reset holds outputs at zero even with din_valid asserted.
    dec_ratio  = RW'(8);
    gain_shift = SW'(9);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, 500);
      check("rst_dout", bus.dout, 0);
      check("rst_dout_valid", bus.dout_valid, 0);
      check("rst_dout_sat", bus.dout_sat, 0);
    end
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b1, 500);
      check("post_rst_dout", bus.dout, 0);
      check("post_rst_dout_sat", bus.dout_sat, 0);
    end

    // DC gain R^N = 512 with shift 9 gives unity; dec_ratio change without restart ignored.
    do_restart(8, 9, 100);
    hsum = 0;
    for (int j = 0; j < hlen; j++) hsum += h[j];
    check("model_gain_r8", hsum, 512);
    dec_ratio = RW'(3);
    for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 1'b1, 100);
    check("dc_pos_dout", last_dout, 100);
    check("dc_pos_sat", last_sat, 0);
    check("dc_pos_strobes", strobe_cnt, 36);

    // Negative DC with a gapped input cadence (two of every three cycles valid).
    do_restart(8, 9, -100);
    for (int i = 0; i < 450; i++) tick(1'b1, 1'b0, (i % 3) != 2, -100);
    check("dc_neg_dout", last_dout, -100);

    // Saturation both ways: 100*512 and -100*512 exceed 16 bits with shift 0.
    do_restart(8, 0, 100);
    for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 1'b1, 100);
    check("sat_pos_dout", last_dout, 32767);
    check("sat_pos_flag", last_sat, 1);
    do_restart(8, 0, -100);
    for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 1'b1, -100);
    check("sat_neg_dout", last_dout, -32768);
    check("sat_neg_flag", last_sat, 1);

    // Impulse at R=4: polyphase sum of boxcar^3 is 4^2 = 16 over 10 strobes.
    do_restart(4, 0, 0);
    for (int i = 0; i < 64; i++) tick(1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++)  tick(1'b1, 1'b0, 1'b0, 0);
    strobe_sum = 0;
    strobe_cnt = 0;
    tick(1'b1, 1'b0, 1'b1, 1);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++)  tick(1'b1, 1'b0, 1'b0, 0);
    check("impulse_sum", strobe_sum, 16);
    check("impulse_strobes", strobe_cnt, 10);
    check("impulse_tail_dout", last_dout, 0);
    check("impulse_tail_sat", last_sat, 0);

    // Full-scale DC long enough for the integrators to wrap many times.
    do_restart(16, 12, 2047);
    for (int i = 0; i < 20000; i++) tick(1'b1, 1'b0, 1'b1, 2047);
    check("wrap_dout", last_dout, 2047);
    check("wrap_sat", last_sat, 0);

    // Mid-stream restarts: first strobe 16 accepts + LAT after the restart edge.
    do_restart(16, 12, 2047);
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0, 1'b1, 2047);
    check("restart_r16_first", first_edge - rs_edge, 21);
    do_restart(0, 12, 2047);
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0, 1'b1, 2047);
    check("restart_r0_first", first_edge - rs_edge, 21);

    // R=1: one strobe per accepted sample, back to back.
    do_restart(1, 0, 7);
    dec_ratio = RW'(5);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b1, ((i * 37) % 201) - 100);
    for (int i = 0; i < 8; i++)  tick(1'b1, 1'b0, 1'b0, 0);
    check("r1_first", first_edge - rs_edge, 6);
    check("r1_strobes", strobe_cnt, 40);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_decim_param.md
# cic_decim_param

Parametrised, runtime-configurable multi-stage CIC decimator, successor to the fixed 3-stage/R=5 CIC in the filter library. It accepts signed samples on a valid strobe, integrates at the input rate, decimates by a programmable ratio and differentiates at the output rate. A programmable arithmetic right shift with saturation produces a fixed-width output. It sits directly after the ADC/front-end sample interface and feeds downstream FIR compensation filters.

## Interface
- NIN, 12: input sample width, signed two's complement.
- NSTAGE, 3: integrator and comb stage count (M=1); legal range 1..6.
- RMAX, 16: maximum decimation ratio; power of two, at least 2.
- NOUT, 16: output width, signed.
- Derived: RW = clog2(RMAX)+1; NMAX = NIN + NSTAGE*clog2(RMAX); SW = clog2(NMAX).
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  reset, synchronous, active-low.
- restart  in  1  synchronous soft clear plus configuration load.
- dec_ratio  in  RW  decimation ratio R, loaded on reset and restart only.
- gain_shift  in  SW  output arithmetic right shift, loaded with dec_ratio.
- din_valid  in  1  input sample strobe; may be high every cycle.
- din  in  NIN  signed input sample.
- dout_valid  out  1  one-cycle output strobe.
- dout  out  NOUT  signed output sample.
- dout_sat  out  1  high with dout_valid when dout was saturated.

## Operation
- **Reset / restart (either rstn=0 or restart=1 at an edge).**
  - Clears all integrators, comb registers, comb delay registers, the decimation counter and every pipeline strobe.
  - dout, dout_valid and dout_sat reset to 0.
  - r_q loads dec_ratio; a value of 0 or above RMAX loads RMAX.
  - s_q loads gain_shift; a value of NMAX or above loads NMAX-1.
  - din_valid in the same cycle is ignored. rstn has priority over restart.
- **Integrators.** NSTAGE registers of NMAX bits, updated only on din_valid:
  - int[0] <= int[0] + sign_extend(din)
  - int[k] <= int[k] + int[k-1]; uses the pre-edge value of int[k-1] (pipelined).
  - Arithmetic is modulo 2^NMAX. Wrap-around is required and must not be detected or clamped.
- **Decimation.**
  - cnt counts accepted samples from 0 to r_q-1 and wraps to 0.
  - An accept with cnt==r_q-1 raises dec_stb the next cycle and captures int[NSTAGE-1] into dec_q.
  - With r_q=1, every accepted sample produces an output.
- **Combs.**
  - NSTAGE registered stages. Stage k updates only while its strobe is high: c[k] <= x - x_d; x_d <= x, where x is dec_q or c[k-1].
  - The strobe advances one stage per cycle, so back-to-back strobes are legal.
  - Arithmetic is modulo 2^NMAX.
- **Output stage.**
  - y = c[NSTAGE-1] >>> s_q (arithmetic shift).
  - If y > 2^(NOUT-1)-1, dout = max and dout_sat = 1. If y < -2^(NOUT-1), dout = min and dout_sat = 1. Otherwise dout = y[NOUT-1:0].
  - dout holds its value between strobes.
- No backpressure; dout must be consumed on dout_valid.

## Timing
- Acceptance edge E0 (din_valid=1, cnt==r_q-1): integrators update at E0; dec_q is captured at E1; comb stage k updates at E(2+k); the output register updates at E(NSTAGE+2).
- dout_valid is high for exactly one cycle, NSTAGE+2 cycles after the acceptance edge (5 for defaults).
- Output strobes are spaced by the input cadence × r_q. They are never merged or dropped, including at r_q=1 with continuous din_valid.
- The first r_q × NSTAGE outputs after reset or restart are transient; the bench ignores them.
- restart while outputs are in flight: the in-flight strobes are killed, and no dout_valid occurs until a full new ratio of inputs has been accepted.
- A change on dec_ratio or gain_shift without restart has no effect.

## Test plan
All scenarios use default parameters (NMAX = 24).
- **Reset values.** Hold rstn=0 for 3 cycles with din_valid=1 and din=500 → dout=0, dout_valid=0 and dout_sat=0 throughout, and for the next 5 cycles after release.
- **DC gain.** R=8, shift=9, din=100 continuous → settled dout=100, one strobe every 8 cycles, latency 5 cycles. The same run with din=-100 → dout=-100.
- **Saturation.** R=8, shift=0, din=100 → dout=32767 and dout_sat=1. With din=-100 → dout=-32768 and dout_sat=1.
- **Impulse.** R=4, shift=0, a single din=1 followed by zeros → the nonzero decimated outputs sum to 16; afterwards dout=0 and dout_sat=0 with strobes continuing.
- **Integrator wrap.** R=16, shift=12, din=2047 continuous for 20000 samples → every settled dout=2047 after the integrators wrap.
- **Reconfiguration.** Pulse restart with R=16 mid-stream → no strobe before 16 new accepts. Then pulse restart with dec_ratio=0 → behaves as R=16. Then dec_ratio=1 → one strobe per accepted sample.
